// File: rtl/histo_pkg.sv
// Shared constants and FSM state type for the histogram accumulator.
package histo_pkg;
  localparam int DATA_W = 128;
  localparam int PIX_W  = 8;
  localparam int CNT_W  = 32;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/histo_fwd_sel.sv
// Picks the freshest count for the bin entering S2: in-flight S3 result,
// then the pending write register, then the scratchpad read data.
module histo_fwd_sel #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 32
) (
  input  logic [PIX_W-1:0] bin,
  input  logic             s3_vld,
  input  logic [PIX_W-1:0] s3_bin,
  input  logic [CNT_W-1:0] s3_res,
  input  logic             wr_vld,
  input  logic [PIX_W-1:0] wr_bin,
  input  logic [CNT_W-1:0] wr_cnt,
  input  logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] cnt
);
  always_comb begin
    cnt = rd_cnt;
    if (s3_vld && s3_bin == bin)      cnt = s3_res;
    else if (wr_vld && wr_bin == bin) cnt = wr_cnt;
  end
endmodule

// File: rtl/histogram_accumulator.sv
// Streams pixels from m1, read-modify-writes saturating bin counts in m2.
// Optional bin clear precedes accumulation; done/overflow are sticky flags.
module histogram_accumulator #(
  parameter int DATA_W = histo_pkg::DATA_W,
  parameter int PIX_W  = histo_pkg::PIX_W,
  parameter int LANES  = DATA_W / PIX_W,
  parameter int CNT_W  = histo_pkg::CNT_W,
  parameter int ADDR_W = histo_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              clear_en,
  output logic [ADDR_W-1:0] m1ReadAddr,
  input  logic [DATA_W-1:0] m1ReadVal,
  output logic [ADDR_W-1:0] m2ReadAddr,
  input  logic [DATA_W-1:0] m2ReadVal,
  output logic [ADDR_W-1:0] m2WriteAddr,
  output logic [DATA_W-1:0] m2WriteVal,
  output logic              m2WE,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  import histo_pkg::*;

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES - 1);

  state_t state, state_nx;
  logic [ADDR_W-1:0] nw_q, word_q;
  logic [LANE_W-1:0] lane_q, lane_s1;
  logic [PIX_W-1:0]  clr_idx, pix_s1, bin_s2, bin_s3, wr_bin;
  logic [CNT_W-1:0]  val_s3, res_s3, wr_cnt, fwd_cnt;
  // vld_pipe[0]=S1 (lane select), [1]=S2 (bin capture), [2]=S3 (increment)
  logic [2:0]        vld_pipe;
  logic accept, issue, last_pix, clr_last, sat_s3;

  assign accept   = start && (state == IDLE || state == DONE);
  assign issue    = (state == RUN);
  assign last_pix = issue && (word_q == nw_q - 1'b1) && (lane_q == LANE_MAX);
  assign clr_last = (state == CLEAR) && (clr_idx == '1);
  assign busy     = (state == CLEAR) || (state == RUN) || (state == DRAIN);

  assign pix_s1      = m1ReadVal[lane_s1*PIX_W +: PIX_W];
  assign m1ReadAddr  = word_q;
  assign m2ReadAddr  = vld_pipe[0] ? ADDR_W'(pix_s1) : '0;
  assign m2WriteAddr = ADDR_W'(wr_bin);
  assign m2WriteVal  = DATA_W'(wr_cnt);

  assign sat_s3 = &val_s3;
  assign res_s3 = sat_s3 ? val_s3 : val_s3 + 1'b1;

  generate
    if (CNT_W < DATA_W) begin : g_unused
      logic unused_rd_hi;
      assign unused_rd_hi = ^m2ReadVal[DATA_W-1:CNT_W];
    end
  endgenerate

  histo_fwd_sel #(.PIX_W(PIX_W), .CNT_W(CNT_W)) u_fwd (
    .bin    (bin_s2),
    .s3_vld (vld_pipe[2]),
    .s3_bin (bin_s3),
    .s3_res (res_s3),
    .wr_vld (m2WE),
    .wr_bin (wr_bin),
    .wr_cnt (wr_cnt),
    .rd_cnt (m2ReadVal[CNT_W-1:0]),
    .cnt    (fwd_cnt)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = clear_en ? CLEAR : (num_words == '0 ? DONE : RUN);
      CLEAR:      if (clr_last) state_nx = (nw_q == '0) ? DONE : RUN;
      RUN:        if (last_pix) state_nx = DRAIN;
      // final write is on the bus once the pipe has emptied
      DRAIN:      if (vld_pipe == '0 && m2WE) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      nw_q     <= '0;
      word_q   <= '0;
      lane_q   <= '0;
      lane_s1  <= '0;
      clr_idx  <= '0;
      bin_s2   <= '0;
      bin_s3   <= '0;
      val_s3   <= '0;
      vld_pipe <= '0;
      m2WE     <= 1'b0;
      wr_bin   <= '0;
      wr_cnt   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], issue};
      lane_s1  <= lane_q;
      bin_s2   <= pix_s1;
      bin_s3   <= bin_s2;
      val_s3   <= fwd_cnt;

      if (accept) begin
        nw_q    <= num_words;
        word_q  <= '0;
        lane_q  <= '0;
        clr_idx <= '0;
      end else if (issue) begin
        if (lane_q == LANE_MAX) begin
          lane_q <= '0;
          if (!last_pix) word_q <= word_q + 1'b1;
        end else begin
          lane_q <= lane_q + 1'b1;
        end
      end else if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
      end

      m2WE   <= (state == CLEAR) || vld_pipe[2];
      wr_bin <= (state == CLEAR) ? clr_idx : bin_s3;
      wr_cnt <= (state == CLEAR) ? '0 : res_s3;

      if (vld_pipe[2] && sat_s3) overflow <= 1'b1;

      if (accept)                done <= (state_nx == DONE);
      else if (state_nx == DONE) done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_histogram_accumulator.sv
// Randomized self-checking bench: bin counts, latency, write counts and
// flags are compared against a plain counting model of each job.
module tb_histogram_accumulator;
  logic         clock, rst, start, clear_en;
  logic [15:0]  num_words, m1ReadAddr, m2ReadAddr, m2WriteAddr;
  logic [127:0] m1ReadVal, m2ReadVal, m2WriteVal;
  logic         m2WE, busy, done, overflow;

  histogram_accumulator dut (
    .clock(clock), .rst(rst), .start(start), .num_words(num_words),
    .clear_en(clear_en), .m1ReadAddr(m1ReadAddr), .m1ReadVal(m1ReadVal),
    .m2ReadAddr(m2ReadAddr), .m2ReadVal(m2ReadVal), .m2WriteAddr(m2WriteAddr),
    .m2WriteVal(m2WriteVal), .m2WE(m2WE), .busy(busy), .done(done),
    .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [127:0] mem1 [64];
  logic [31:0]  mem2 [256];
  logic [31:0]  ref_bins [256];
  logic         ref_ovf;
  int           we_total = 0;
  logic [15:0]  m1_max;
  logic         stat_clr, pre_we, pre_zero;
  logic [7:0]   pre_a;
  logic [31:0]  pre_v;
  int           n_cmp = 0, n_err = 0;

  // scratchpad returns the data being written on the same edge (write-first)
  always @(posedge clock) begin
    if (pre_zero) for (int i = 0; i < 256; i++) mem2[i] <= '0;
    else if (pre_we) mem2[pre_a] <= pre_v;
    if (m2WE) begin
      mem2[m2WriteAddr[7:0]] <= m2WriteVal[31:0];
      we_total <= we_total + 1;
    end
    m2ReadVal <= (m2WE && m2WriteAddr == m2ReadAddr) ? m2WriteVal
                                                     : {96'd0, mem2[m2ReadAddr[7:0]]};
    m1ReadVal <= mem1[m1ReadAddr[5:0]];
    if (stat_clr) m1_max <= '0;
    else if (busy && m1ReadAddr > m1_max) m1_max <= m1ReadAddr;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    @(negedge clock); pre_we = 1'b1; pre_a = 8'(a); pre_v = v;
    @(negedge clock); pre_we = 1'b0;
    ref_bins[a] = v;
  endtask

  task automatic run_job(input int nw, input bit clr, input string tag);
    int lat, w0, exp_lat, exp_we;
    logic [7:0] p;
    if (clr) for (int i = 0; i < 256; i++) ref_bins[i] = '0;
    for (int w = 0; w < nw; w++)
      for (int l = 0; l < 16; l++) begin
        p = mem1[w][l*8 +: 8];
        if (ref_bins[p] == 32'hFFFF_FFFF) ref_ovf = 1'b1;
        else ref_bins[p] = ref_bins[p] + 1;
      end
    exp_we  = nw * 16 + (clr ? 256 : 0);
    exp_lat = (nw == 0) ? (clr ? 256 : 0) : nw * 16 + 4 + (clr ? 256 : 0);
    @(negedge clock); stat_clr = 1'b1;
    @(negedge clock); stat_clr = 1'b0; w0 = we_total;
    start = 1'b1; num_words = 16'(nw); clear_en = clr;
    @(negedge clock); start = 1'b0;
    chk({tag, "_done_at_accept"}, done, exp_lat == 0);
    chk({tag, "_busy"}, busy, exp_lat != 0);
    lat = 0;
    while (!done && lat < 4000) begin @(negedge clock); lat++; end
    chk({tag, "_latency"}, lat, exp_lat);
    repeat (3) @(negedge clock);
    chk({tag, "_writes"}, we_total - w0, exp_we);
    if (nw > 0) chk({tag, "_m1addr_max"}, m1_max, nw - 1);
    for (int i = 0; i < 256; i++)
      chk($sformatf("%s_bin%0d", tag, i), mem2[i], ref_bins[i]);
    chk({tag, "_overflow"}, overflow, ref_ovf);
  endtask

  initial begin
    logic [7:0] a, b, x, y;
    int nw;
    rst = 1'b0; start = 1'b0; clear_en = 1'b0; num_words = '0;
    stat_clr = 1'b0; pre_we = 1'b0; pre_zero = 1'b0; pre_a = '0; pre_v = '0;
    ref_ovf = 1'b0;
    for (int i = 0; i < 64; i++) mem1[i] = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_we", m2WE, 0);
    chk("rst_m1addr", m1ReadAddr, 0);
    chk("rst_m2addr", m2ReadAddr, 0);
    rst = 1'b0;

    // clear then one word of distinct pixels 0..15
    for (int l = 0; l < 16; l++) mem1[0][l*8 +: 8] = 8'(l);
    run_job(1, 1'b1, "clr_distinct");

    // two words of one repeated pixel on prezeroed bins
    @(negedge clock); pre_zero = 1'b1;
    @(negedge clock); pre_zero = 1'b0;
    for (int i = 0; i < 256; i++) ref_bins[i] = '0;
    mem1[0] = {16{8'h7F}}; mem1[1] = {16{8'h7F}};
    run_job(2, 1'b0, "same_pix");

    // A,A,B,A repeating across word boundaries
    a = 8'($urandom_range(0, 255));
    b = a + 8'($urandom_range(1, 255));
    for (int w = 0; w < 3; w++)
      for (int l = 0; l < 16; l++) mem1[w][l*8 +: 8] = (l % 4 == 2) ? b : a;
    run_job(3, 1'b0, "aaba");

    // random jobs with a narrow pixel range to stress forwarding
    for (int j = 0; j < 4; j++) begin
      nw = $urandom_range(1, 5);
      x = 8'($urandom_range(0, 250));
      for (int w = 0; w < nw; w++)
        for (int l = 0; l < 16; l++) mem1[w][l*8 +: 8] = x + 8'($urandom_range(0, 3));
      run_job(nw, 1'($urandom_range(0, 1)), $sformatf("rand%0d", j));
    end

    // saturation: bin preloaded one below max, hit three times
    x = 8'($urandom_range(0, 255));
    y = x ^ 8'h55;
    for (int l = 0; l < 16; l++) mem1[0][l*8 +: 8] = (l == 0 || l == 1 || l == 5) ? x : y;
    preload(x, 32'hFFFF_FFFE);
    run_job(1, 1'b0, "sat");
    chk("sat_bin_max", mem2[x], 32'hFFFF_FFFF);

    // empty job
    run_job(0, 1'b0, "empty");

    // reset in the middle of a run, then a fresh job
    for (int w = 0; w < 4; w++) mem1[w] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clock); start = 1'b1; num_words = 16'd4; clear_en = 1'b0;
    @(negedge clock); start = 1'b0;
    repeat (20) @(negedge clock);
    @(posedge clock); #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_we", m2WE, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_m1addr", m1ReadAddr, 0);
    chk("midrst_m2addr", m2ReadAddr, 0);
    ref_ovf = 1'b0;
    @(negedge clock); rst = 1'b0;
    @(posedge clock); #1;
    chk("postrst_we", m2WE, 0);
    run_job(2, 1'b1, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
